// File: rtl/ay8913_bus_arbiter.sv
// Two-requester write arbiter for the AY-3-8913 two-phase register bus.
// Keeps a masked shadow of PSG registers 0..13 for readback.
module ay8913_bus_arbiter #(
    parameter logic [3:0] IDLE_ADDR   = 4'hF,
    parameter bit         ROUND_ROBIN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [3:0] a_addr,
    input  logic [7:0] a_data,
    input  logic       b_valid,
    output logic       b_ready,
    input  logic [3:0] b_addr,
    input  logic [7:0] b_data,
    output logic [7:0] psg_data,
    output logic       busy,
    input  logic [3:0] rd_addr,
    output logic [7:0] rd_data
);

    typedef enum logic {
        PH_DATA = 1'b0,
        PH_ADDR = 1'b1
    } phase_t;

    phase_t     phase_q;
    phase_t     phase_d;
    logic       last_b;
    logic       grant_a;
    logic       grant_b;
    logic       a_hs;
    logic       b_hs;
    logic       hs;
    logic [3:0] sel_addr;
    logic [7:0] sel_data;
    logic [3:0] hold_addr;
    logic [7:0] hold_data;
    logic [7:0] shadow [0:13];

    function automatic logic [7:0] reg_mask(input logic [3:0] r);
        case (r)
            4'd0, 4'd2, 4'd4, 4'd11, 4'd12: reg_mask = 8'hFF;
            4'd1, 4'd3, 4'd5, 4'd13:        reg_mask = 8'h0F;
            4'd6, 4'd8, 4'd9, 4'd10:        reg_mask = 8'h1F;
            4'd7:                           reg_mask = 8'h3F;
            default:                        reg_mask = 8'h00;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_DATA;
        end else begin
            phase_q <= phase_d;
        end
    end

    always_comb begin
        phase_d = PH_DATA;
        if (phase_q == PH_DATA) begin
            phase_d = PH_ADDR;
        end
    end

    // last_b set means B won the previous grant, so A wins the next tie
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (a_valid && b_valid) begin
            grant_a = ROUND_ROBIN ? last_b : 1'b1;
            grant_b = !grant_a;
        end else begin
            grant_a = a_valid;
            grant_b = b_valid;
        end
    end

    assign a_ready  = (phase_q == PH_DATA) && grant_a;
    assign b_ready  = (phase_q == PH_DATA) && grant_b;
    assign a_hs     = a_valid && a_ready;
    assign b_hs     = b_valid && b_ready;
    assign hs       = a_hs || b_hs;
    assign sel_addr = a_hs ? a_addr : b_addr;
    assign sel_data = a_hs ? a_data : b_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psg_data  <= 8'h00;
            busy      <= 1'b0;
            hold_addr <= 4'h0;
            hold_data <= 8'h00;
            last_b    <= 1'b1;
        end else if (phase_q == PH_DATA) begin
            if (hs) begin
                psg_data  <= {4'h0, sel_addr};
                hold_addr <= sel_addr;
                hold_data <= sel_data;
                busy      <= 1'b1;
                if (ROUND_ROBIN) begin
                    last_b <= b_hs;
                end
            end else begin
                psg_data <= {4'h0, IDLE_ADDR};
                busy     <= 1'b0;
            end
        end else begin
            psg_data <= busy ? hold_data : 8'h00;
        end
    end

    // The PSG latches hold_data at the edge ending the data cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 14; i++) begin
                shadow[i] <= 8'h00;
            end
        end else if (phase_q == PH_DATA && busy && hold_addr < 4'd14) begin
            shadow[hold_addr] <= hold_data & reg_mask(hold_addr);
        end
    end

    assign rd_data = (rd_addr < 4'd14) ? shadow[rd_addr] : 8'h00;

endmodule
